// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: controller state encoding, register/NOP constants
// and the bundle of pipeline-register controls driven by pipeline_ctrl.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Field order matches the bit order used when the bundle is viewed as a vector.
  typedef struct packed {
    logic pc_write;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_stall;
    logic memwb_bubble;
    logic halt;
  } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the instruction in ID reads.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rd_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       load_use_o
);

  // Writes to r0 are discarded, so they never create a dependence.
  assign load_use_o = idex_memread_i && (idex_rd_i != REG_ZERO) &&
                      ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: RUN/MEM_WAIT/HALT FSM with memory watchdog, combinational
// pipeline-register controls, and free-running stall/flush event counters.
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rd_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_write_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        exmem_stall_o,
  output logic        memwb_bubble_o,
  output logic        halt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  // Memory handshake: mem_req_i marks an access by the instruction in MEM; the
  // access completes in the cycle mem_ack_i is high, and every earlier cycle of
  // that request (mem_req_i high, mem_ack_i low) freezes the pipeline.

  localparam logic [7:0] WD_LIMIT = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d, cur_state;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        load_use, mem_miss, freeze, run_rules;
  ctrl_t       ctrl;

  hazard_detect u_hazard_detect (
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs_i      (ifid_rs_i),
    .ifid_rt_i      (ifid_rt_i),
    .load_use_o     (load_use)
  );

  assign mem_miss = mem_req_i && !mem_ack_i;
  // During reset the controls already follow RUN rules so the pipeline keeps moving.
  assign cur_state = rst_n_i ? state_q : ST_RUN;

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    freeze    = 1'b0;
    run_rules = 1'b0;
    case (cur_state)
      ST_RUN: begin
        if (mem_miss) begin
          freeze  = 1'b1;
          state_d = ST_MEM_WAIT;
          wd_d    = 8'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          run_rules = 1'b1;
          state_d   = ST_RUN;
        end else begin
          freeze = 1'b1;
          if (wd_q == WD_LIMIT) state_d = ST_HALT;
          else                  wd_d    = wd_q + 8'd1;
        end
      end
      ST_HALT: freeze = 1'b1;
      default: begin
        freeze  = 1'b1;
        state_d = ST_HALT;
      end
    endcase
  end

  always_comb begin
    ctrl          = '0;
    ctrl.pc_write = 1'b1;
    if (freeze) begin
      ctrl.pc_write     = 1'b0;
      ctrl.ifid_stall   = 1'b1;
      ctrl.exmem_stall  = 1'b1;
      ctrl.memwb_bubble = 1'b1;
      ctrl.halt         = (cur_state == ST_HALT);
    end else if (run_rules) begin
      // A load-use stall wins over a taken branch whose operands may come from the load.
      if (load_use) begin
        ctrl.pc_write    = 1'b0;
        ctrl.ifid_stall  = 1'b1;
        ctrl.idex_bubble = 1'b1;
      end else if (branch_taken_i || jump_i) begin
        ctrl.ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_RUN;
      wd_q        <= 8'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      stall_cnt_q <= stall_cnt_q + 32'(!ctrl.pc_write);
      flush_cnt_q <= flush_cnt_q + 32'(ctrl.ifid_flush);
    end
  end

  assign pc_write_o     = ctrl.pc_write;
  assign ifid_stall_o   = ctrl.ifid_stall;
  assign ifid_flush_o   = ctrl.ifid_flush;
  assign idex_bubble_o  = ctrl.idex_bubble;
  assign exmem_stall_o  = ctrl.exmem_stall;
  assign memwb_bubble_o = ctrl.memwb_bubble;
  assign halt_o         = ctrl.halt;
  assign stall_cnt_o    = stall_cnt_q;
  assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short watchdog limit (4).
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        idex_memread, branch_taken, jump, mem_req, mem_ack;
  logic [4:0]  idex_rd, ifid_rs, ifid_rt;
  logic        pc_write, ifid_stall, ifid_flush, idex_bubble;
  logic        exmem_stall, memwb_bubble, halt;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctrl_obs;

  int tests_run = 0;
  int tests_failed = 0;

  // Control vectors: {pc_write, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble, halt}
  localparam logic [6:0] C_NORM   = 7'b1000000;
  localparam logic [6:0] C_LU     = 7'b0101000;
  localparam logic [6:0] C_FLUSH  = 7'b1010000;
  localparam logic [6:0] C_FREEZE = 7'b0100110;
  localparam logic [6:0] C_HALT   = 7'b0100111;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .mem_req_i      (mem_req),
    .mem_ack_i      (mem_ack),
    .pc_write_o     (pc_write),
    .ifid_stall_o   (ifid_stall),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_stall_o  (exmem_stall),
    .memwb_bubble_o (memwb_bubble),
    .halt_o         (halt),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  assign ctrl_obs = {pc_write, ifid_stall, ifid_flush, idex_bubble,
                     exmem_stall, memwb_bubble, halt};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    branch_taken = 1'b0; jump = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1-2 time units after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    settle();
    check("ctrl_in_reset", 32'(ctrl_obs), 32'(C_NORM));
    tick();
    rst_n = 1'b1;
    settle();
    check("reset_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);
    tick();

    // Load-use on rt: one stall cycle, then the load has moved on.
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rt = 5'd5; ifid_rs = 5'd1;
    settle();
    check("lu_rt_ctrl", 32'(ctrl_obs), 32'(C_LU));
    tick();
    idle();
    settle();
    check("lu_after_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    check("lu_stall_cnt", stall_cnt, 32'd1);
    tick();

    // Load to r0 never stalls.
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    settle();
    check("lu_r0_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    tick();
    // Load-use on rs.
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd7; ifid_rt = 5'd3;
    settle();
    check("lu_rs_ctrl", 32'(ctrl_obs), 32'(C_LU));
    tick();
    // Matching register but not a load.
    idex_memread = 1'b0;
    settle();
    check("no_load_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    check("lu_rs_stall_cnt", stall_cnt, 32'd2);
    tick();

    // Miss with ack on the 4th cycle: 3 freeze cycles, branch ignored while frozen.
    idle();
    mem_req = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("miss_freeze_%0d", i), 32'(ctrl_obs), 32'(C_FREEZE));
      tick();
    end
    mem_ack = 1'b1;
    settle();
    check("miss_ack_ctrl", 32'(ctrl_obs), 32'(C_FLUSH));
    check("miss_stall_cnt", stall_cnt, 32'd5);
    tick();
    idle();
    settle();
    check("miss_after_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    check("miss_flush_cnt", flush_cnt, 32'd1);
    tick();

    // Load-use with a taken branch: stall first, flush once LU clears.
    idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs = 5'd9; branch_taken = 1'b1;
    settle();
    check("lu_br_ctrl", 32'(ctrl_obs), 32'(C_LU));
    tick();
    idex_memread = 1'b0;
    settle();
    check("br_after_lu_ctrl", 32'(ctrl_obs), 32'(C_FLUSH));
    check("lu_br_stall_cnt", stall_cnt, 32'd6);
    check("lu_br_flush_cnt", flush_cnt, 32'd1);
    tick();
    idle();
    jump = 1'b1;
    settle();
    check("jump_ctrl", 32'(ctrl_obs), 32'(C_FLUSH));
    check("jump_flush_cnt_before", flush_cnt, 32'd2);
    tick();
    idle();
    settle();
    check("jump_flush_cnt", flush_cnt, 32'd3);

    // Timeout: one RUN miss cycle plus 4 MEM_WAIT cycles, then HALT.
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("timeout_wait_%0d", i), 32'(ctrl_obs), 32'(C_FREEZE));
      tick();
    end
    settle();
    check("halt_ctrl", 32'(ctrl_obs), 32'(C_HALT));
    check("halt_stall_cnt", stall_cnt, 32'd11);
    tick();
    mem_req = 1'b0; mem_ack = 1'b1;
    settle();
    check("halt_ack_ignored", 32'(ctrl_obs), 32'(C_HALT));
    tick();
    idle();
    settle();
    check("halt_sticky", 32'(ctrl_obs), 32'(C_HALT));
    check("halt_stall_cnt_inc", stall_cnt, 32'd13);

    // Reset out of HALT.
    rst_n = 1'b0;
    settle();
    check("halt_in_reset_ctrl", 32'(ctrl_obs), 32'(C_NORM));
    tick();
    rst_n = 1'b1;
    settle();
    check("post_reset_halt", 32'(halt), 32'd0);
    check("post_reset_stall_cnt", stall_cnt, 32'd0);
    check("post_reset_flush_cnt", flush_cnt, 32'd0);
    idex_memread = 1'b1; idex_rd = 5'd4; ifid_rt = 5'd4;
    settle();
    check("post_reset_lu", 32'(ctrl_obs), 32'(C_LU));
    tick();
    idle();
    settle();
    check("post_reset_stall_cnt_lu", stall_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the 5-stage pipeline. It generates hold, flush and bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Hazard sources are load-use dependences, branches and jumps resolved in ID, and multi-cycle data-memory accesses. A watchdog counter and performance counters sit alongside; the block lives beside the hazard-detection logic in the CPU top level.

## Interface
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before HALT; 8-bit counter range, 1..255.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_n_i` input 1: synchronous, active-low reset.
- `idex_memread_i` input 1: instruction in EX is a load.
- `idex_rd_i` input 5: destination register of the instruction in EX.
- `ifid_rs_i` input 5: rs field of the instruction in ID.
- `ifid_rt_i` input 5: rt field of the instruction in ID.
- `branch_taken_i` input 1: branch in ID resolved taken.
- `jump_i` input 1: jump in ID.
- `mem_req_i` input 1: instruction in MEM accesses data memory.
- `mem_ack_i` input 1: data memory completes the access this cycle.
- `pc_write_o` output 1: PC update enable.
- `ifid_stall_o` output 1: IF/ID hold.
- `ifid_flush_o` output 1: IF/ID instruction cleared to 0.
- `idex_bubble_o` output 1: ID/EX loads a NOP.
- `exmem_stall_o` output 1: EX/MEM hold.
- `memwb_bubble_o` output 1: MEM/WB loads a NOP.
- `halt_o` output 1: memory timeout; the pipeline is frozen.
- `stall_cnt_o` output 32: count of cycles with `pc_write_o` = 0.
- `flush_cnt_o` output 32: count of cycles with `ifid_flush_o` = 1.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. State is registered.
- Outputs are combinational from the current state and the inputs.
- Load-use hazard (LU): `idex_memread_i` && `idex_rd_i` != 0 && (`idex_rd_i` == `ifid_rs_i` || `idex_rd_i` == `ifid_rt_i`).
- Memory miss (MM): `mem_req_i` && !`mem_ack_i`.
- Priority, highest first:
  - HALT.
  - MM or state MEM_WAIT without ack.
  - LU.
  - branch or jump.
  - normal.
- Freeze (MM, or MEM_WAIT with `mem_ack_i` = 0):
  - `pc_write_o` = 0, `ifid_stall_o` = 1, `exmem_stall_o` = 1, `memwb_bubble_o` = 1.
  - `idex_bubble_o` = 0: ID/EX is held through its write enable, which is tied to `ifid_stall_o`.
  - Branch and jump are ignored during freeze; they are re-evaluated once it lifts.
- LU (no freeze):
  - `pc_write_o` = 0, `ifid_stall_o` = 1, `idex_bubble_o` = 1, `ifid_flush_o` = 0.
  - A simultaneous `branch_taken_i` is suppressed, because its operands may depend on the load.
- Branch taken or jump (no freeze, no LU): `pc_write_o` = 1, `ifid_flush_o` = 1.
- Normal: `pc_write_o` = 1; all other controls 0.
- Transitions:
  - RUN→MEM_WAIT on MM; the watchdog loads 1.
  - MEM_WAIT→RUN on `mem_ack_i`. In that ack cycle the outputs follow the RUN rules (LU, branch, normal).
  - MEM_WAIT→HALT when the watchdog equals `MEM_TIMEOUT` and there is no ack. Otherwise the watchdog increments by 1.
  - HALT is left only by reset.
- HALT outputs: freeze outputs plus `halt_o` = 1.
- Counters: 32-bit, wrap modulo 2^32, increment in any state including HALT.

## Timing
- Reset (`rst_n_i` = 0 at a rising edge):
  - State = RUN; watchdog, `stall_cnt_o` and `flush_cnt_o` = 0.
  - Reset overrides any in-progress MEM_WAIT or HALT.
  - While reset is asserted, outputs follow the RUN rules for the current inputs.
  - `halt_o` = 0 from the cycle after the reset edge.
- LU costs exactly 1 stall cycle. The next cycle the load is in MEM and ID/EX holds a bubble, so LU deasserts.
- A miss of N cycles (ack on the Nth cycle after the request) gives N freeze cycles; the ack cycle itself is not frozen.
- A branch costs 1 flushed fetch.
- Counter outputs are registered and reflect events up to the previous cycle.

## Structure
- Shared package `cpu_pkg`:
  - state encoding: RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2.
  - `REG_ZERO` = 5'd0.
  - NOP instruction constant 32'h0.
- Sub-module `hazard_detect` (combinational LU comparator). The FSM, watchdog and counters stay in `pipeline_ctrl`.

## Test plan
- Load-use: `idex_memread_i`=1, `idex_rd_i`=5, `ifid_rt_i`=5, no memory request → 1 cycle of `pc_write_o`=0, `ifid_stall_o`=1, `idex_bubble_o`=1; then normal; `stall_cnt_o`=1.
- Zero register: `idex_rd_i`=0, `ifid_rs_i`=0, `idex_memread_i`=1 → no stall.
- Miss: `mem_req_i`=1, ack on the 4th cycle → 3 freeze cycles, then RUN; `stall_cnt_o`=3.
- LU + branch same cycle → stall with `ifid_flush_o`=0; next cycle `branch_taken_i` still 1 → `ifid_flush_o`=1; `flush_cnt_o`=1.
- Timeout: `MEM_TIMEOUT`=4, `mem_req_i` held with no ack → `halt_o`=1 after 4 wait cycles and stays set.
- Reset out of HALT: assert `rst_n_i`=0 → next cycle `halt_o`=0, both counters 0.
